// File: rtl/arq_receiver.sv
// Go-back-N style ARQ receiver: delivers in-order frames through a one-deep
// output register and produces coalesced cumulative acknowledgements.
module arq_receiver #(
  parameter int DATA_W = 32,
  parameter int SEQ_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_p,
  input  logic [SEQ_W-1:0]  in_seq,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_payload,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic [SEQ_W-1:0]  ack_seq
);

  logic [SEQ_W-1:0] expected;
  logic             delivered_any;
  logic             accept;
  logic             in_order;
  logic             ack_event;
  logic [SEQ_W-1:0] ack_seq_next;

  // Output register can take a new word whenever it is empty or draining.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign in_order = accept && (in_seq == expected);

  // Out-of-order frames re-ack the last delivered seq once anything was delivered.
  assign ack_event    = in_order || (accept && !in_order && delivered_any);
  assign ack_seq_next = in_order ? in_seq : expected - 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      expected      <= '0;
      delivered_any <= 1'b0;
      out_valid     <= 1'b0;
      out_payload   <= '0;
    end else if (in_order) begin
      expected      <= expected + 1'b1;
      delivered_any <= 1'b1;
      out_valid     <= 1'b1;
      out_payload   <= in_p;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  // Ack register is independent of the data path; a newer event overwrites a pending one.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_valid <= 1'b0;
      ack_seq   <= '0;
    end else if (ack_event) begin
      ack_valid <= 1'b1;
      ack_seq   <= ack_seq_next;
    end else if (ack_valid && ack_ready) begin
      ack_valid <= 1'b0;
    end
  end

endmodule
